// File: rtl/pathfinding_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pathfinding_pkg                                                          |
// | Shared node record layout and open-list sizing for the pathfinder.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pathfinding_pkg;

  localparam int          QUEUE_DEPTH   = 128;
  localparam int          QUEUE_ADDR_W  = 7;
  localparam int          NODE_W        = 272;
  localparam logic [15:0] EMPTY_NODE_ID = 16'h0000;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] node_id;
    logic [15:0] parent_node_id;
    logic [15:0] current_cost;
    logic [15:0] child0_id;
    logic [15:0] child0_dist;
    logic [15:0] child1_id;
    logic [15:0] child1_dist;
    logic [15:0] child2_id;
    logic [15:0] child2_dist;
    logic [15:0] child3_id;
    logic [15:0] child3_dist;
    logic [15:0] child4_id;
    logic [15:0] child4_dist;
    logic [15:0] child5_id;
    logic [15:0] child5_dist;
  } node_info;

  function automatic logic node_is_valid(input node_info n);
    return n.node_id != EMPTY_NODE_ID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/queue_node_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | queue_node_ram                                                           |
// | 128 x 272 simple dual-port RAM, synchronous read (old data on collision).|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module queue_node_ram
  import pathfinding_pkg::*;
(
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [QUEUE_ADDR_W-1:0] waddr_i,
  input  logic [NODE_W-1:0]       wdata_i,
  input  logic [QUEUE_ADDR_W-1:0] raddr_i,
  output logic [NODE_W-1:0]       rdata_o
);

  logic [NODE_W-1:0] mem_q [QUEUE_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule
`default_nettype wire

// File: rtl/pathfinding_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pathfinding_queue                                                        |
// | Open-list store with sequential minimum-cost and child-lookup scans.     |
// | Optional macro QUEUE_FREE_SLOT_EN: report first free slot on child miss. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pathfinding_queue
  import pathfinding_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [QUEUE_ADDR_W-1:0] write_address,
  input  logic [NODE_W-1:0]       write_data,
  input  logic                    find_minimum,
  input  logic                    find_child,
  input  logic [NODE_W-1:0]       current_child,
  output logic                    busy,
  output logic [NODE_W-1:0]       minimum_node,
  output logic [QUEUE_ADDR_W-1:0] minimum_address,
  output logic                    minimum_valid,
  output logic                    minimum_done,
  output logic [NODE_W-1:0]       child_from_queue,
  output logic                    child_queued,
  output logic [QUEUE_ADDR_W-1:0] child_address,
  output logic                    child_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [7:0]              idx_q;
  logic                    mode_min_q;

  logic [QUEUE_ADDR_W-1:0] rd_addr;
  logic [NODE_W-1:0]       rd_data;
  node_info                rd_node;
  node_info                child_key;
  logic [QUEUE_ADDR_W-1:0] data_addr;
  logic                    cmp_en;
  logic                    unused_child_key;

  logic                    min_found_q, min_found_d;
  node_info                min_node_q, min_node_d;
  logic [QUEUE_ADDR_W-1:0] min_addr_q, min_addr_d;
  logic                    child_found_q, child_found_d;
  node_info                child_node_q, child_node_d;
  logic [QUEUE_ADDR_W-1:0] child_addr_q, child_addr_d;
  logic [QUEUE_ADDR_W-1:0] child_addr_res;

  // idx_q counts edges since the find was sampled; the word returned now
  // belongs to the address presented one cycle earlier.
  assign rd_addr   = idx_q[QUEUE_ADDR_W-1:0];
  assign data_addr = idx_q[QUEUE_ADDR_W-1:0] - 7'd1;
  assign cmp_en    = ((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && (idx_q != 8'd0);
  assign rd_node   = node_info'(rd_data);
  assign child_key = node_info'(current_child);
  assign unused_child_key = ^child_key;

  queue_node_ram u_ram (
    .clk     (clk),
    .we_i    (write_enable),
    .waddr_i (write_address),
    .wdata_i (write_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    min_found_d   = min_found_q;
    min_node_d    = min_node_q;
    min_addr_d    = min_addr_q;
    child_found_d = child_found_q;
    child_node_d  = child_node_q;
    child_addr_d  = child_addr_q;
    if (cmp_en && mode_min_q) begin
      if (node_is_valid(rd_node) &&
          (!min_found_q || (rd_node.current_cost < min_node_q.current_cost))) begin
        min_found_d = 1'b1;
        min_node_d  = rd_node;
        min_addr_d  = data_addr;
      end
    end
    if (cmp_en && !mode_min_q && !child_found_q && node_is_valid(child_key) &&
        (rd_node.node_id == child_key.node_id)) begin
      child_found_d = 1'b1;
      child_node_d  = rd_node;
      child_addr_d  = data_addr;
    end
  end

`ifdef QUEUE_FREE_SLOT_EN
  logic                    free_found_q, free_found_d;
  logic [QUEUE_ADDR_W-1:0] free_addr_q, free_addr_d;

  always_comb begin
    free_found_d = free_found_q;
    free_addr_d  = free_addr_q;
    if (cmp_en && !mode_min_q && !free_found_q && !node_is_valid(rd_node)) begin
      free_found_d = 1'b1;
      free_addr_d  = data_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_found_q <= 1'b0;
      free_addr_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      free_found_q <= 1'b0;
      free_addr_q  <= '0;
    end else begin
      free_found_q <= free_found_d;
      free_addr_q  <= free_addr_d;
    end
  end

  assign child_addr_res = child_found_d ? child_addr_d :
                          (free_found_d ? free_addr_d : '0);
`else
  assign child_addr_res = child_found_d ? child_addr_d : '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      idx_q            <= 8'd0;
      mode_min_q       <= 1'b0;
      min_found_q      <= 1'b0;
      min_node_q       <= '0;
      min_addr_q       <= '0;
      child_found_q    <= 1'b0;
      child_node_q     <= '0;
      child_addr_q     <= '0;
      busy             <= 1'b0;
      minimum_node     <= '0;
      minimum_address  <= '0;
      minimum_valid    <= 1'b0;
      minimum_done     <= 1'b0;
      child_from_queue <= '0;
      child_queued     <= 1'b0;
      child_address    <= '0;
      child_done       <= 1'b0;
    end else begin
      minimum_done <= 1'b0;
      child_done   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (find_minimum || find_child) begin
            state_q       <= ST_SCAN;
            idx_q         <= 8'd0;
            mode_min_q    <= find_minimum;
            min_found_q   <= 1'b0;
            min_node_q    <= '0;
            min_addr_q    <= '0;
            child_found_q <= 1'b0;
            child_node_q  <= '0;
            child_addr_q  <= '0;
          end
        end
        ST_SCAN: begin
          min_found_q   <= min_found_d;
          min_node_q    <= min_node_d;
          min_addr_q    <= min_addr_d;
          child_found_q <= child_found_d;
          child_node_q  <= child_node_d;
          child_addr_q  <= child_addr_d;
          idx_q         <= idx_q + 8'd1;
          if (idx_q == 8'd0) begin
            busy <= 1'b1;
          end
          if (idx_q == 8'd127) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last word (address 127) is folded in while publishing.
          state_q <= ST_DONE;
          if (mode_min_q) begin
            minimum_valid   <= min_found_d;
            minimum_node    <= min_node_d;
            minimum_address <= min_addr_d;
            minimum_done    <= 1'b1;
          end else begin
            child_queued     <= child_found_d;
            child_from_queue <= child_node_d;
            child_address    <= child_addr_res;
            child_done       <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pathfinding_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pathfinding_queue                                                     |
// | Directed self-checking bench for the open-list scan engine.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pathfinding_queue;

  logic         clk;
  logic         reset;
  logic         write_enable;
  logic [6:0]   write_address;
  logic [271:0] write_data;
  logic         find_minimum;
  logic         find_child;
  logic [271:0] current_child;
  logic         busy;
  logic [271:0] minimum_node;
  logic [6:0]   minimum_address;
  logic         minimum_valid;
  logic         minimum_done;
  logic [271:0] child_from_queue;
  logic         child_queued;
  logic [6:0]   child_address;
  logic         child_done;

  int checks;
  int failures;
  int min_done_at, child_done_at, min_cnt, child_cnt;
  logic busy_e1, busy_e130;

`ifdef QUEUE_FREE_SLOT_EN
  localparam logic [6:0] C_FREE3 = 7'd3;
`else
  localparam logic [6:0] C_FREE3 = 7'd0;
`endif

  pathfinding_queue dut (
    .clk              (clk),
    .reset            (reset),
    .write_enable     (write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .find_minimum     (find_minimum),
    .find_child       (find_child),
    .current_child    (current_child),
    .busy             (busy),
    .minimum_node     (minimum_node),
    .minimum_address  (minimum_address),
    .minimum_valid    (minimum_valid),
    .minimum_done     (minimum_done),
    .child_from_queue (child_from_queue),
    .child_queued     (child_queued),
    .child_address    (child_address),
    .child_done       (child_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [271:0] mk(input logic [15:0] id, input logic [15:0] cost);
    return {id + 16'd1, id + 16'd2, id, id ^ 16'h00FF, cost, {6{id, cost}}};
  endfunction

  task automatic write_rec(input logic [6:0] addr, input logic [271:0] data);
    @(negedge clk);
    write_enable  = 1'b1;
    write_address = addr;
    write_data    = data;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 128; i++) write_rec(7'(i), '0);
  endtask

  // Edge n of the loop is E0+n; samples are taken 1 time unit after it.
  task automatic run_scan(input logic fm, input logic fc, input int late_child_at, input int ncyc);
    @(negedge clk);
    find_minimum = fm;
    find_child   = fc;
    @(posedge clk);
    #1;
    find_minimum = 1'b0;
    find_child   = 1'b0;
    min_done_at = -1; child_done_at = -1; min_cnt = 0; child_cnt = 0;
    busy_e1 = 1'b0; busy_e130 = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      if (late_child_at > 0) find_child = (n == late_child_at);
      if (minimum_done) begin
        min_cnt++;
        if (min_done_at < 0) min_done_at = n;
      end
      if (child_done) begin
        child_cnt++;
        if (child_done_at < 0) child_done_at = n;
      end
      if (n == 1) busy_e1 = busy;
      if (n == 130) busy_e130 = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (minimum_valid !== 1'b0 || minimum_done !== 1'b0 || minimum_address !== 7'd0) begin
      failures++; $display("FAIL reset_min: got valid=%b done=%b addr=%0d expected 0/0/0", minimum_valid, minimum_done, minimum_address); end
    checks++; if (minimum_node !== 272'd0 || child_from_queue !== 272'd0) begin
      failures++; $display("FAIL reset_nodes: got min=%h child=%h expected 0", minimum_node, child_from_queue); end
    checks++; if (child_queued !== 1'b0 || child_done !== 1'b0 || child_address !== 7'd0) begin
      failures++; $display("FAIL reset_child: got q=%b done=%b addr=%0d expected 0/0/0", child_queued, child_done, child_address); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_minimum();
    run_scan(1'b1, 1'b0, 0, 132);
    checks++; if (min_done_at !== 129 || min_cnt !== 1) begin
      failures++; $display("FAIL min_done_timing: got edge %0d count %0d expected 129/1", min_done_at, min_cnt); end
    checks++; if (busy_e1 !== 1'b1 || busy_e130 !== 1'b0) begin
      failures++; $display("FAIL min_busy: got E1=%b E130=%b expected 1/0", busy_e1, busy_e130); end
    checks++; if (minimum_valid !== 1'b1 || minimum_address !== 7'd1) begin
      failures++; $display("FAIL min_result: got valid=%b addr=%0d expected 1/1", minimum_valid, minimum_address); end
    checks++; if (minimum_node !== mk(16'h0016, 16'd16)) begin
      failures++; $display("FAIL min_node: got %h expected %h", minimum_node, mk(16'h0016, 16'd16)); end
  endtask

  task automatic test_child_hit();
    logic [271:0] r;
    current_child = mk(16'h0016, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    r = child_from_queue;
    checks++; if (child_done_at !== 129 || child_cnt !== 1 || min_cnt !== 0) begin
      failures++; $display("FAIL child_done_timing: got edge %0d count %0d min %0d expected 129/1/0", child_done_at, child_cnt, min_cnt); end
    checks++; if (child_queued !== 1'b1 || child_address !== 7'd1 || r[207:192] !== 16'd16) begin
      failures++; $display("FAIL child_hit: got q=%b addr=%0d cost=%0d expected 1/1/16", child_queued, child_address, r[207:192]); end
    checks++; if (minimum_valid !== 1'b1 || minimum_address !== 7'd1) begin
      failures++; $display("FAIL min_retained: got valid=%b addr=%0d expected 1/1", minimum_valid, minimum_address); end
  endtask

  task automatic test_child_miss();
    current_child = mk(16'h0055, 16'd7);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b0 || child_address !== C_FREE3 || child_from_queue !== 272'd0) begin
      failures++; $display("FAIL child_miss: got q=%b addr=%0d node=%h expected 0/%0d/0", child_queued, child_address, child_from_queue, C_FREE3); end
    current_child = '0;
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b0 || child_address !== C_FREE3) begin
      failures++; $display("FAIL child_zero_id: got q=%b addr=%0d expected 0/%0d", child_queued, child_address, C_FREE3); end
  endtask

  task automatic test_edges();
    write_rec(7'd127, mk(16'h0040, 16'd5));
    write_rec(7'd5, mk(16'h0030, 16'hFFFF));
    run_scan(1'b1, 1'b0, 0, 132);
    checks++; if (minimum_valid !== 1'b1 || minimum_address !== 7'd127 || minimum_node !== mk(16'h0040, 16'd5)) begin
      failures++; $display("FAIL min_last_addr: got valid=%b addr=%0d node=%h expected 1/127", minimum_valid, minimum_address, minimum_node); end
    current_child = mk(16'h0040, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b1 || child_address !== 7'd127) begin
      failures++; $display("FAIL child_last_addr: got q=%b addr=%0d expected 1/127", child_queued, child_address); end
    current_child = mk(16'h0030, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b1 || child_address !== 7'd5 || child_from_queue !== mk(16'h0030, 16'hFFFF)) begin
      failures++; $display("FAIL child_addr5: got q=%b addr=%0d expected 1/5", child_queued, child_address); end
  endtask

  task automatic test_both_pulses();
    current_child = mk(16'h0013, 16'd0);
    run_scan(1'b1, 1'b1, 10, 132);
    checks++; if (min_cnt !== 1 || min_done_at !== 129 || child_cnt !== 0) begin
      failures++; $display("FAIL both_pulses: got min %0d at %0d child %0d expected 1/129/0", min_cnt, min_done_at, child_cnt); end
    checks++; if (child_address !== 7'd5 || child_queued !== 1'b1 || minimum_address !== 7'd127) begin
      failures++; $display("FAIL both_retained: got caddr=%0d q=%b maddr=%0d expected 5/1/127", child_address, child_queued, minimum_address); end
  endtask

  task automatic test_back_to_back();
    run_scan(1'b1, 1'b0, 0, 130);
    checks++; if (min_done_at !== 129 || busy_e130 !== 1'b0) begin
      failures++; $display("FAIL b2b_first: got edge %0d busy %b expected 129/0", min_done_at, busy_e130); end
    current_child = mk(16'h0013, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_cnt !== 1 || child_done_at !== 129 || child_queued !== 1'b1 || child_address !== 7'd0) begin
      failures++; $display("FAIL b2b_second: got cnt %0d at %0d q=%b addr=%0d expected 1/129/1/0", child_cnt, child_done_at, child_queued, child_address); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    find_minimum = 1'b1;
    @(posedge clk);
    #1;
    find_minimum = 1'b0;
    repeat (49) @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || minimum_valid !== 1'b0 || minimum_address !== 7'd0 || minimum_node !== 272'd0) begin
      failures++; $display("FAIL midreset_min: got busy=%b valid=%b addr=%0d expected 0/0/0", busy, minimum_valid, minimum_address); end
    checks++; if (child_queued !== 1'b0 || child_address !== 7'd0 || child_from_queue !== 272'd0) begin
      failures++; $display("FAIL midreset_child: got q=%b addr=%0d expected 0/0", child_queued, child_address); end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 140; n++) begin
      @(posedge clk);
      #1;
      if (minimum_done || child_done || busy) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL midreset_nodone: got %0d active cycles expected 0", dones); end
    run_scan(1'b1, 1'b0, 0, 132);
    checks++; if (minimum_valid !== 1'b1 || minimum_address !== 7'd127 || minimum_node !== mk(16'h0040, 16'd5)) begin
      failures++; $display("FAIL midreset_rescan: got valid=%b addr=%0d expected 1/127", minimum_valid, minimum_address); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 128; i++) write_rec(7'(i), mk(16'(i + 256), 16'(1000 - i)));
    run_scan(1'b1, 1'b0, 0, 132);
    checks++; if (minimum_address !== 7'd127 || minimum_node !== mk(16'd383, 16'd873)) begin
      failures++; $display("FAIL full_min: got addr=%0d expected 127", minimum_address); end
    current_child = mk(16'h0155, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b1 || child_address !== 7'h55) begin
      failures++; $display("FAIL full_child_hit: got q=%b addr=%0d expected 1/85", child_queued, child_address); end
    current_child = mk(16'h0999, 16'd0);
    run_scan(1'b0, 1'b1, 0, 132);
    checks++; if (child_queued !== 1'b0 || child_address !== 7'd0 || child_from_queue !== 272'd0) begin
      failures++; $display("FAIL full_no_free: got q=%b addr=%0d expected 0/0", child_queued, child_address); end
  endtask

  task automatic test_empty();
    clear_all();
    run_scan(1'b1, 1'b0, 0, 132);
    checks++; if (min_cnt !== 1 || minimum_valid !== 1'b0 || minimum_address !== 7'd0 || minimum_node !== 272'd0) begin
      failures++; $display("FAIL empty_min: got cnt %0d valid=%b addr=%0d expected 1/0/0", min_cnt, minimum_valid, minimum_address); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; write_enable = 1'b0; write_address = '0; write_data = '0;
    find_minimum = 1'b0; find_child = 1'b0; current_child = '0;
    test_reset();
    clear_all();
    write_rec(7'd0, mk(16'h0013, 16'd800));
    write_rec(7'd1, mk(16'h0016, 16'd16));
    write_rec(7'd2, mk(16'h0020, 16'd16));
    test_minimum();
    test_child_hit();
    test_child_miss();
    test_edges();
    test_both_pulses();
    test_back_to_back();
    test_reset_mid();
    test_full();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
